// File: rtl/btb_types_pkg.sv
// Shared BTB types: default geometry, entry layout, sweep FSM states and counter encodings.
// BTB_2BIT_EN adds the per-entry direction counter to the entry layout.
package btb_types_pkg;

  localparam int BTB_ADDR_W  = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W   = BTB_ADDR_W - BTB_IDX_W - 2;
  localparam int BTB_TGT_W   = BTB_ADDR_W - 2;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_t;

  // Layout at the default geometry; the top rebuilds it at its own parameter widths.
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] target;
`ifdef BTB_2BIT_EN
    logic [1:0]           cnt;
`endif
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next value of a 2-bit saturating up/down direction counter.
// Zero latency; no flow control.
module sat_counter2
  import btb_types_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_up,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_up) begin
      if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: same-cycle lookup, one-edge training write, ENTRIES-cycle invalidate sweep (busy).
// Define BTB_2BIT_EN for 2-bit direction counters; otherwise every hit predicts taken.
module branch_target_buffer
  import btb_types_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int ADDR_W  = BTB_ADDR_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush,
  output logic              busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int TGT_W = ADDR_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
`ifdef BTB_2BIT_EN
    logic [1:0]       cnt;
`endif
  } entry_t;

  logic [ENTRIES-1:0] r_valid;
  entry_t             r_entry [ENTRIES];
  btb_state_t         r_state;
  btb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic               w_ptr_last;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  entry_t             w_lk_ent;

  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  entry_t             w_up_ent;
  logic               w_up_hit;
  logic               w_upd_go;
  logic               w_wr_en;
  logic               w_inval;
  entry_t             w_wr_ent;
  logic               w_unused_bits;

  assign w_unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign w_lk_ent = r_entry[w_lk_idx];

  assign pred_hit = r_valid[w_lk_idx] & (w_lk_ent.tag == w_lk_tag) & ~busy;
`ifdef BTB_2BIT_EN
  assign pred_taken = pred_hit & w_lk_ent.cnt[1];
`else
  assign pred_taken = pred_hit;
`endif
  assign pred_target = pred_taken ? {w_lk_ent.target, 2'b00} : lookup_pc + ADDR_W'(4);

  assign w_ptr_last = (r_ptr == IDX_W'(ENTRIES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A flush seen mid-sweep keeps the FSM in SWEEP and restarts the pointer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (flush) w_state_nxt = SWEEP;
      SWEEP:   if (!flush && w_ptr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SWEEP);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      r_ptr <= '0;
    else if (flush) r_ptr <= '0;
    else if (busy)  r_ptr <= r_ptr + IDX_W'(1);
  end

  assign w_upd_go = upd_en & ~flush & (r_state == IDLE);
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign w_up_ent = r_entry[w_up_idx];
  assign w_up_hit = r_valid[w_up_idx] & (w_up_ent.tag == w_up_tag);

`ifdef BTB_2BIT_EN
  logic [1:0] w_cnt_nxt;

  sat_counter2 u_sat_counter2 (
    .i_cnt (w_up_ent.cnt),
    .i_up  (upd_taken),
    .o_cnt (w_cnt_nxt)
  );
`endif

  always_comb begin
    w_wr_en  = 1'b0;
    w_inval  = 1'b0;
    w_wr_ent = w_up_ent;
    if (w_upd_go) begin
      if (w_up_hit) begin
        w_wr_en = upd_taken;
        if (upd_taken) w_wr_ent.target = upd_target[ADDR_W-1:2];
`ifdef BTB_2BIT_EN
        w_wr_en      = 1'b1;
        w_wr_ent.cnt = w_cnt_nxt;
`else
        w_inval = ~upd_taken;
`endif
      end else if (upd_taken) begin
        w_wr_en         = 1'b1;
        w_wr_ent.tag    = w_up_tag;
        w_wr_ent.target = upd_target[ADDR_W-1:2];
`ifdef BTB_2BIT_EN
        w_wr_ent.cnt    = CNT_WT;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (busy) begin
      r_valid[r_ptr] <= 1'b0;
    end else if (w_wr_en) begin
      r_valid[w_up_idx] <= 1'b1;
    end else if (w_inval) begin
      r_valid[w_up_idx] <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) r_entry[i] <= '0;
    end else if (w_wr_en) begin
      r_entry[w_up_idx] <= w_wr_ent;
    end
  end

endmodule
